// File: rtl/proc_trace_checker.sv
// proc_trace_checker: in-order (addr,data) trace scoreboard with idle watchdog and saturating error count.
// Optional first-mismatch capture (index/addr/data) is enabled by defining TRACE_CHECK_LOG_EN.
module proc_trace_checker #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned ERR_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_val,
    output logic                     load_rdy,
    input  logic [ADDR_W-1:0]        load_addr,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     load_dc,
    input  logic                     start,
    input  logic                     clear,
    input  logic                     trace_val,
    input  logic [ADDR_W-1:0]        trace_addr,
    input  logic [DATA_W-1:0]        trace_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic [ERR_W-1:0]         err_count,
    output logic [$clog2(DEPTH)-1:0] first_idx,
    output logic [ADDR_W-1:0]        first_addr,
    output logic [DATA_W-1:0]        first_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [ERR_W-1:0]   err_d;
    logic               tmo_d;
    logic               busy_d, done_d, pass_d, load_rdy_d;
    logic               load_ok, load_fire, mismatch;

    // Expected-entry table; contents need no reset.
    logic [ADDR_W-1:0]  tbl_addr [DEPTH];
    logic [DATA_W-1:0]  tbl_data [DEPTH];
    logic [DEPTH-1:0]   tbl_dc;

    always_ff @(posedge clk) begin
        if (load_fire) begin
            tbl_addr[count_q[IDX_W-1:0]] <= load_addr;
            tbl_data[count_q[IDX_W-1:0]] <= load_data;
            tbl_dc[count_q[IDX_W-1:0]]   <= load_dc;
        end
    end

    assign load_ok   = (state_q == S_IDLE) && (count_q < CNT_W'(DEPTH));
    assign load_fire = load_val && load_ok && !clear;
    assign mismatch  = (trace_addr != tbl_addr[rd_ptr_q]) ||
                       (!tbl_dc[rd_ptr_q] && (trace_data != tbl_data[rd_ptr_q]));

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        timer_d  = timer_q;
        err_d    = err_count;
        tmo_d    = timeout;

        unique case (state_q)
            S_IDLE: begin
                if (clear) begin
                    count_d = '0;
                end else begin
                    if (load_fire) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (start) begin
                        rd_ptr_d = '0;
                        timer_d  = '0;
                        err_d    = '0;
                        tmo_d    = 1'b0;
                        state_d  = (count_q == '0) ? S_DONE : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (trace_val) begin
                    rd_ptr_d = rd_ptr_q + IDX_W'(1);
                    timer_d  = '0;
                    if (mismatch && (err_count != '1)) begin
                        err_d = err_count + ERR_W'(1);
                    end
                    if (CNT_W'(rd_ptr_q) == (count_q - CNT_W'(1))) begin
                        state_d = S_DONE;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_DONE: begin
                if (clear) begin
                    count_d = '0;
                    err_d   = '0;
                    tmo_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d == S_RUN);
        done_d     = (state_d == S_DONE);
        pass_d     = done_d && (err_d == '0) && !tmo_d;
        load_rdy_d = (state_d == S_IDLE) && (count_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            timer_q   <= '0;
            err_count <= '0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            load_rdy  <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            timer_q   <= timer_d;
            err_count <= err_d;
            timeout   <= tmo_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            load_rdy  <= load_rdy_d;
        end
    end

`ifdef TRACE_CHECK_LOG_EN
    logic log_clr, log_cap;

    // Cleared by an accepted start or a clear; captures only while no error has been counted yet.
    assign log_clr = ((state_q == S_IDLE) && start && !clear) || ((state_q == S_DONE) && clear);
    assign log_cap = (state_q == S_RUN) && trace_val && mismatch && (err_count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_idx  <= '0;
            first_addr <= '0;
            first_data <= '0;
        end else if (log_clr) begin
            first_idx  <= '0;
            first_addr <= '0;
            first_data <= '0;
        end else if (log_cap) begin
            first_idx  <= rd_ptr_q;
            first_addr <= trace_addr;
            first_data <= trace_data;
        end
    end
`else
    assign first_idx  = '0;
    assign first_addr = '0;
    assign first_data = '0;
`endif

endmodule

// File: tb/tb_proc_trace_checker.sv
// Scoreboard bench for proc_trace_checker: directed scenarios plus random transactions against a list-based model.
module tb_proc_trace_checker;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned TMO   = 12;
    localparam int unsigned EW    = 2;
    localparam int unsigned IW    = 3;
    localparam int unsigned EMAX  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_val, load_rdy, load_dc;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          start, clear, trace_val;
    logic [AW-1:0] trace_addr;
    logic [DW-1:0] trace_data;
    logic          busy, done, pass, timeout;
    logic [EW-1:0] err_count;
    logic [IW-1:0] first_idx;
    logic [AW-1:0] first_addr;
    logic [DW-1:0] first_data;

    proc_trace_checker #(
        .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .ERR_W(EW)
    ) dut (
        .clk(clk), .rst(rst),
        .load_val(load_val), .load_rdy(load_rdy), .load_addr(load_addr),
        .load_data(load_data), .load_dc(load_dc),
        .start(start), .clear(clear),
        .trace_val(trace_val), .trace_addr(trace_addr), .trace_data(trace_data),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_idx(first_idx),
        .first_addr(first_addr), .first_data(first_data)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          pass;
        logic [EW-1:0] err;
        logic          tmo;
        logic [IW-1:0] fidx;
        logic [AW-1:0] faddr;
        logic [DW-1:0] fdata;
        int unsigned   cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic done_prev = 1'b0;

    // Stimulus description for one transaction.
    logic [AW-1:0] l_addr [DEPTH+2];
    logic [DW-1:0] l_data [DEPTH+2];
    bit            l_dc   [DEPTH+2];
    int            n_load;
    logic [AW-1:0] t_addr [DEPTH];
    logic [DW-1:0] t_data [DEPTH];
    int            t_gap  [DEPTH];
    int            n_tr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising done is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 64'(done), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("pass", 64'(pass), 64'(mon_e.pass));
                chk("err_count", 64'(err_count), 64'(mon_e.err));
                chk("timeout", 64'(timeout), 64'(mon_e.tmo));
                chk("busy_at_done", 64'(busy), 64'd0);
                chk("first_idx", 64'(first_idx), 64'(mon_e.fidx));
                chk("first_addr", 64'(first_addr), 64'(mon_e.faddr));
                chk("first_data", 64'(first_data), 64'(mon_e.fdata));
            end
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ent(input int i, input int a, input int d, input bit dc);
        l_addr[i] = AW'(a);
        l_data[i] = DW'(d);
        l_dc[i]   = dc;
    endtask

    task automatic set_tr(input int j, input int a, input int d, input int g);
        t_addr[j] = AW'(a);
        t_data[j] = DW'(d);
        t_gap[j]  = g;
    endtask

    task automatic load_all();
        for (int i = 0; i < n_load; i++) begin
            chk("load_rdy", 64'(load_rdy), 64'(i < DEPTH));
            load_val  = 1'b1;
            load_addr = l_addr[i];
            load_data = l_data[i];
            load_dc   = l_dc[i];
            tick();
        end
        load_val = 1'b0;
    endtask

    // Reference: outcome from the expected list and the observed trace list.
    function automatic exp_t model(input int n_ent);
        exp_t e;
        int errs = 0;
        e.fidx = '0; e.faddr = '0; e.fdata = '0; e.cyc = 0;
        for (int j = 0; j < n_tr; j++) begin
            if ((t_addr[j] != l_addr[j]) || (!l_dc[j] && (t_data[j] != l_data[j]))) begin
`ifdef TRACE_CHECK_LOG_EN
                if (errs == 0) begin
                    e.fidx  = IW'(j);
                    e.faddr = t_addr[j];
                    e.fdata = t_data[j];
                end
`endif
                errs++;
            end
        end
        e.err  = EW'((errs > int'(EMAX)) ? int'(EMAX) : errs);
        e.tmo  = (n_ent > 0) && (n_tr < n_ent);
        e.pass = (e.err == '0) && !e.tmo;
        return e;
    endfunction

    task automatic run_txn(input bit clr_with_start, input bit noise);
        int n_ent = (n_load > int'(DEPTH)) ? int'(DEPTH) : n_load;
        int unsigned last_ev;
        int w;
        exp_t e;
        load_all();
        e = model(n_ent);
        start   = 1'b1;
        last_ev = cyc;
        if (n_ent == 0) begin
            e.cyc = last_ev + 1;
            sb.push_back(e);
        end
        tick();
        start = 1'b0;
        if (n_ent > 0) chk("busy_after_start", 64'(busy), 64'd1);
        for (int j = 0; j < n_tr; j++) begin
            for (int k = 0; k < t_gap[j]; k++) begin
                clear = noise && ($urandom_range(0, 5) == 0);
                start = noise && ($urandom_range(0, 5) == 0);
                tick();
                clear = 1'b0;
                start = 1'b0;
            end
            trace_val  = 1'b1;
            trace_addr = t_addr[j];
            trace_data = t_data[j];
            last_ev    = cyc;
            if ((j == n_tr - 1) && (n_tr == n_ent)) begin
                e.cyc = last_ev + 1;
                sb.push_back(e);
            end
            tick();
            trace_val = 1'b0;
        end
        if (e.tmo) begin
            e.cyc = last_ev + 1 + TMO;
            sb.push_back(e);
        end
        w = 0;
        while ((sb.size() != 0) && (w < int'(3 * TMO + 10))) begin
            tick();
            w++;
        end
        if (sb.size() != 0) begin
            chk("wait_done", 64'(done), 64'd1);
            sb.delete();
        end
        tick();
        // Trace activity in DONE must not disturb the result.
        trace_val  = 1'b1;
        trace_addr = AW'($urandom);
        trace_data = DW'($urandom);
        tick();
        trace_val = 1'b0;
        chk("done_hold", 64'(done), 64'd1);
        chk("err_hold_in_done", 64'(err_count), 64'(e.err));
        clear = 1'b1;
        start = clr_with_start;
        tick();
        clear = 1'b0;
        start = 1'b0;
        chk("clear_done", 64'(done), 64'd0);
        chk("clear_load_rdy", 64'(load_rdy), 64'd1);
        tick();
        chk("clear_no_start_busy", 64'(busy), 64'd0);
        chk("clear_no_start_done", 64'(done), 64'd0);
    endtask

    task automatic gen_random();
        int n_ent;
        n_load = $urandom_range(0, DEPTH + 2);
        n_ent  = (n_load > int'(DEPTH)) ? int'(DEPTH) : n_load;
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            l_addr[i] = AW'($urandom);
            l_data[i] = DW'($urandom);
            l_dc[i]   = ($urandom_range(0, 3) == 0);
        end
        n_tr = n_ent;
        if ((n_ent > 0) && ($urandom_range(0, 4) == 0)) n_tr = $urandom_range(0, n_ent - 1);
        for (int j = 0; j < n_tr; j++) begin
            t_addr[j] = l_addr[j];
            t_data[j] = l_data[j];
            case ($urandom_range(0, 5))
                0: t_addr[j] = t_addr[j] ^ (AW'(1) << $urandom_range(0, AW - 1));
                1: t_data[j] = t_data[j] ^ (DW'(1) << $urandom_range(0, DW - 1));
                default: ;
            endcase
            t_gap[j] = ($urandom_range(0, 7) == 0) ? int'(TMO) - 1 : int'($urandom_range(0, 3));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        load_val = 1'b0; load_addr = '0; load_data = '0; load_dc = 1'b0;
        start = 1'b0; clear = 1'b0;
        trace_val = 1'b0; trace_addr = '0; trace_data = '0;
        repeat (2) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_load_rdy", 64'(load_rdy), 64'd1);
        chk("rst_first_addr", 64'(first_addr), 64'd0);
        rst = 1'b1;
        tick();

        // Matching trace, don't-care data on the third entry.
        n_load = 3;
        set_ent(0, 'h000, 'h2, 0); set_ent(1, 'h004, 'h3, 0); set_ent(2, 'h008, 'h0, 1);
        n_tr = 3;
        set_tr(0, 'h000, 'h2, 0); set_tr(1, 'h004, 'h3, 1); set_tr(2, 'h008, 'h55, 0);
        run_txn(0, 0);

        // Data mismatch on the second entry.
        set_tr(1, 'h004, 'h4, 0);
        run_txn(0, 0);

        // Branch skip: address mismatch on the third entry.
        set_ent(2, 'h00c, 'h0, 1);
        set_tr(1, 'h004, 'h3, 0); set_tr(2, 'h008, 'h7, 2);
        run_txn(0, 0);

        // Overfill then watchdog; clear with start together afterwards.
        n_load = DEPTH + 2;
        for (int i = 0; i < int'(DEPTH) + 2; i++) set_ent(i, 4 * i, i, 0);
        n_tr = 1;
        set_tr(0, 'h000, 'h0, 0);
        run_txn(1, 0);

        // Empty table passes immediately.
        n_load = 0;
        n_tr   = 0;
        run_txn(1, 0);

        // Random transactions.
        for (int t = 0; t < 40; t++) begin
            gen_random();
            run_txn($urandom_range(0, 1) == 1, 1);
        end

        // Asynchronous reset in the middle of a run.
        n_load = 3;
        set_ent(0, 'h100, 'h1, 0); set_ent(1, 'h104, 'h2, 0); set_ent(2, 'h108, 'h3, 0);
        load_all();
        start = 1'b1;
        tick();
        start      = 1'b0;
        trace_val  = 1'b1;
        trace_addr = AW'('h1ff);
        trace_data = DW'('h1);
        tick();
        trace_val = 1'b0;
        chk("pre_reset_err", 64'(err_count), 64'd1);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_done", 64'(done), 64'd0);
        chk("async_rst_err", 64'(err_count), 64'd0);
        chk("async_rst_load_rdy", 64'(load_rdy), 64'd1);
        tick();
        rst = 1'b1;
        tick();

        // Fresh transaction after reset.
        gen_random();
        run_txn(0, 0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
